tinyrv_spi_mem_responder: RTL and testbench
===========================================

// Module: tinyrv_spi_mem_responder
// PURPOSE
// - Synthesizable SPI-mode-0 memory target: the far end of the tinyrv core's serial memory bus.
// - Answers READ (0x03) and WRITE (0x02) commands from a small internal byte RAM.
// - Used in tb and FPGA bring-up in place of an external SPI SRAM.
// - Oversamples SPI pins on the system clock.
// PARAMETERS
// - DEPTH   256  RAM size in bytes, power of two; address bits above log2(DEPTH) are ignored.
// - ADDR_W  24   address bits carried on the wire after the opcode.
// PORTS
// - clk          in   1  system clock; SCK frequency <= clk/4.
// - rst_n        in   1  asynchronous active-low reset.
// - spi_cs_n     in   1  chip select, active low.
// - spi_sck      in   1  serial clock from the initiator.
// - spi_mosi     in   1  initiator -> responder data.
// - spi_miso     out  1  responder -> initiator data.
// - spi_miso_oe  out  1  high while driving spi_miso (for uio_oe).
// - busy         out  1  high from CS fall to CS rise.
// - cmd_err      out  1  one-clk pulse when an unsupported opcode completes.
// BEHAVIOUR
// - Reset (async, rst_n=0): spi_miso=0, spi_miso_oe=0, busy=0, cmd_err=0, state=IDLE, counters=0.
// - RAM contents are not reset.
// - cs_n, sck and mosi pass through 2-FF synchronizers.
// - SCK rise/fall and CS fall/rise are edge-detected on synchronized values.
// - Effective pin-to-action latency is 3 clk.
// - Mode 0: MOSI sampled on SCK rise; MISO updated on SCK fall; all bytes MSB first.
// - States: IDLE -> CMD (8 bits) -> ADDR (ADDR_W bits) -> RD_DATA | WR_DATA; IGNORE.
// - CS fall in IDLE -> CMD, with bit counter cleared.
// - After the 8th CMD bit:
//   - 0x03 or 0x02 -> ADDR.
//   - Other values -> IGNORE and one-clk cmd_err pulse.
// - After ADDR_W address bits:
//   - Address pointer = addr[log2(DEPTH)-1:0].
//   - Next state is RD_DATA for READ, WR_DATA for WRITE.
// - RD_DATA:
//   - On entry, RAM[ptr] is loaded into the shift register.
//   - Bit 7 is driven on the first SCK fall after the last address bit.
//   - Each following fall shifts out one bit.
//   - After 8 bits: ptr increments and RAM[ptr] is reloaded before the next fall.
// - WR_DATA:
//   - 8 sampled bits form a byte.
//   - The byte is written to RAM[ptr] on the clk after the 8th rise; then ptr increments.
// - ptr wraps from DEPTH-1 to 0 in both directions of transfer.
// - spi_miso_oe = 1 only in RD_DATA while CS is low; spi_miso = 0 whenever oe = 0.
// - CS rise in any state:
//   - Immediate return to IDLE; oe drops on the same clk the edge is detected.
//   - Partial write byte is discarded; partial command or address is discarded without cmd_err.
// - IGNORE: MOSI is ignored and MISO stays undriven until CS rise.
// - SCK edges while CS is high are ignored.
// - A CS fall in the same clk as a SCK edge: the CS fall wins and the SCK edge is dropped.
// - Reset mid-transfer aborts; the next transaction must start with a fresh CS fall.
// STRUCTURE
// - Package tinyrv_spi_pkg holds:
//   - SPI_CMD_READ=8'h03 and SPI_CMD_WRITE=8'h02.
//   - The state enum {IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE}.
//   - Default ADDR_W.
// - Sub-module tinyrv_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs.
//   - Instantiated once each for cs_n, sck and mosi (mosi uses the level only).
// - RAM: a single reg array, one write port, one read port.
// TESTING
// - WRITE 0x02, addr 0x000010, data A5 3C, CS high:
//   - Then READ 0x03 at 0x000010 for 2 bytes; MISO returns A5 3C.
//   - spi_miso_oe is high only during the data phase.
// - Write 0x11 at 0x0000FF, then 0x22 to the next byte:
//   - The second write lands at 0x00.
//   - Read 2 bytes from 0xFF -> 11 22 (wrap-around).
// - Address 0xABCD10 behaves identically to 0x000010 when DEPTH=256 (upper bits ignored).
// - Opcode 0x9F:
//   - cmd_err pulses exactly once.
//   - MISO stays undriven for 32 further SCKs.
//   - busy drops on CS rise; RAM is unchanged.
// - WRITE to 0x20, 5 data bits, CS rise:
//   - RAM[0x20] keeps its old value.
//   - The next READ of 0x20 returns the old value.
// - rst_n low mid-read:
//   - All outputs go to their reset values immediately.
//   - After release, a new READ returns correct data.

Source files
------------

// File: rtl/tinyrv_spi_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the tinyrv SPI memory responder.
`timescale 1ns/1ps
package tinyrv_spi_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam int unsigned SPI_ADDR_W_DEFAULT = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    IGNORE
  } spi_state_e;

  function automatic logic spi_cmd_supported(input logic [7:0] cmd);
    return (cmd == SPI_CMD_READ) || (cmd == SPI_CMD_WRITE);
  endfunction

endpackage

// File: rtl/tinyrv_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with single-clk rise/fall pulses.
`timescale 1ns/1ps
module tinyrv_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resetting to 0 means a CS held low through reset produces no fall edge,
  // so a transfer can only begin with a genuine CS fall after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/tinyrv_spi_mem_responder.sv
// SPI mode-0 memory target answering READ/WRITE from an internal byte RAM,
// with all SPI pins oversampled on the system clock.
`timescale 1ns/1ps
module tinyrv_spi_mem_responder
  import tinyrv_spi_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = SPI_ADDR_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic cmd_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = (ADDR_W > 8) ? $clog2(ADDR_W) : 3;

  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_unused_lvl, sck_rise, sck_fall;
  logic mosi, mosi_unused_rise, mosi_unused_fall;

  tinyrv_sync_edge u_sync_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_cs_n),
    .level(cs_lvl),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  tinyrv_sync_edge u_sync_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_sck),
    .level(sck_unused_lvl),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  tinyrv_sync_edge u_sync_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_mosi),
    .level(mosi),
    .rise (mosi_unused_rise),
    .fall (mosi_unused_fall)
  );

  // SCK edges count only while selected, and lose to a simultaneous CS fall.
  logic sck_rise_ok, sck_fall_ok;
  assign sck_rise_ok = sck_rise & ~cs_lvl & ~cs_fall;
  assign sck_fall_ok = sck_fall & ~cs_lvl & ~cs_fall;

  spi_state_e       state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [6:0]       cmd_sh;
  logic [AW-2:0]    addr_sh;
  logic [6:0]       wr_sh;
  logic [7:0]       rd_sh;
  logic [AW-1:0]    ptr;
  logic             is_read;
  logic             miso_q;
  logic             load_req;
  logic             wr_pend;
  logic [7:0]       wr_byte;

  logic [7:0]    cmd_next;
  logic [AW-1:0] addr_next;
  logic [7:0]    wr_next;

  // Only the low AW address bits are kept, so upper wire bits fall away.
  assign cmd_next  = {cmd_sh, mosi};
  assign addr_next = {addr_sh, mosi};
  assign wr_next   = {wr_sh, mosi};

  logic cnt_clr, cnt_inc, err_set, cmd_latch, ptr_load, rd_req, rd_next_byte, wr_done;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    err_set      = 1'b0;
    cmd_latch    = 1'b0;
    ptr_load     = 1'b0;
    rd_req       = 1'b0;
    rd_next_byte = 1'b0;
    wr_done      = 1'b0;
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state_nxt = CMD;
            cnt_clr   = 1'b1;
          end
        end
        CMD: begin
          if (sck_rise_ok) begin
            if (bit_cnt == BYTE_LAST) begin
              cnt_clr   = 1'b1;
              cmd_latch = 1'b1;
              if (spi_cmd_supported(cmd_next)) begin
                state_nxt = ADDR;
              end else begin
                state_nxt = IGNORE;
                err_set   = 1'b1;
              end
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        ADDR: begin
          if (sck_rise_ok) begin
            if (bit_cnt == ADDR_LAST) begin
              cnt_clr  = 1'b1;
              ptr_load = 1'b1;
              if (is_read) begin
                state_nxt = RD_DATA;
                rd_req    = 1'b1;
              end else begin
                state_nxt = WR_DATA;
              end
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        RD_DATA: begin
          if (sck_fall_ok) begin
            if (bit_cnt == BYTE_LAST) begin
              cnt_clr      = 1'b1;
              rd_next_byte = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (sck_rise_ok) begin
            if (bit_cnt == BYTE_LAST) begin
              cnt_clr = 1'b1;
              wr_done = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        IGNORE: begin
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      cmd_sh   <= '0;
      addr_sh  <= '0;
      wr_sh    <= '0;
      rd_sh    <= '0;
      ptr      <= '0;
      is_read  <= 1'b0;
      miso_q   <= 1'b0;
      load_req <= 1'b0;
      wr_pend  <= 1'b0;
      wr_byte  <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= err_set;

      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;

      if (state == CMD && sck_rise_ok)     cmd_sh  <= cmd_next[6:0];
      if (cmd_latch)                       is_read <= (cmd_next == SPI_CMD_READ);
      if (state == ADDR && sck_rise_ok)    addr_sh <= addr_next[AW-2:0];
      if (state == WR_DATA && sck_rise_ok) wr_sh   <= wr_next[6:0];

      if (ptr_load)                     ptr <= addr_next;
      else if (wr_pend || rd_next_byte) ptr <= ptr + 1'b1;

      // A fetch is requested after the pointer settles and completes one clk
      // later, well before the next SCK fall given SCK <= clk/4.
      if (rd_req || rd_next_byte) load_req <= 1'b1;
      else                        load_req <= 1'b0;

      if (ptr_load) begin
        miso_q <= 1'b0;
      end else if (load_req) begin
        rd_sh <= mem[ptr];
      end else if (state == RD_DATA && sck_fall_ok) begin
        miso_q <= rd_sh[7];
        rd_sh  <= {rd_sh[6:0], 1'b0};
      end

      wr_pend <= wr_done;
      if (wr_done) wr_byte <= wr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_pend) mem[ptr] <= wr_byte;
  end

  assign spi_miso_oe = (state == RD_DATA) && !cs_lvl;
  assign spi_miso    = spi_miso_oe & miso_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_tinyrv_spi_mem_responder.sv
// Directed bench for the SPI memory responder with a read-data scoreboard.
`timescale 1ns/1ps
module tb_tinyrv_spi_mem_responder;
  import tinyrv_spi_pkg::*;

  localparam int unsigned HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic miso, oe, busy, cmd_err;

  always #5 clk = ~clk;

  tinyrv_spi_mem_responder #(.DEPTH(256), .ADDR_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_cs_n   (cs_n),
    .spi_sck    (sck),
    .spi_mosi   (mosi),
    .spi_miso   (miso),
    .spi_miso_oe(oe),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned err_hits = 0;
  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic oe_all, oe_any;

  always @(negedge clk) if (cmd_err === 1'b1) err_hits++;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
    rx = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(HALF);
      rx = {rx[6:0], miso};
      oe_all = oe_all & oe;
      oe_any = oe_any | oe;
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic spi_begin();
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic spi_end();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic spi_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] d;
    oe_any = 1'b0;
    oe_all = 1'b1;
    spi_bits(cmd, 8, d);
    spi_bits(addr[23:16], 8, d);
    spi_bits(addr[15:8], 8, d);
    spi_bits(addr[7:0], 8, d);
  endtask

  task automatic do_write(input logic [23:0] addr, input int unsigned n,
                          input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] d;
    logic [7:0] idx;
    spi_begin();
    check("wr_busy", 32'(busy), 32'd1);
    spi_hdr(SPI_CMD_WRITE, addr);
    for (int unsigned i = 0; i < n; i++) begin
      spi_bits((i == 0) ? b0 : b1, 8, d);
      idx = addr[7:0] + 8'(i);
      model[idx] = (i == 0) ? b0 : b1;
    end
    check("wr_oe", 32'(oe_any), 32'd0);
    spi_end();
  endtask

  task automatic do_read(input string tag, input logic [23:0] addr, input int unsigned n);
    logic [7:0] rx;
    logic [7:0] idx;
    for (int unsigned i = 0; i < n; i++) begin
      idx = addr[7:0] + 8'(i);
      exp_q.push_back(model[idx]);
    end
    spi_begin();
    spi_hdr(SPI_CMD_READ, addr);
    check({tag, "_hdr_oe"}, 32'(oe_any), 32'd0);
    for (int unsigned i = 0; i < n; i++) begin
      oe_all = 1'b1;
      spi_bits(8'h00, 8, rx);
      check({tag, "_data"}, 32'(rx), 32'(exp_q.pop_front()));
      check({tag, "_data_oe"}, 32'(oe_all), 32'd1);
    end
    spi_end();
    check({tag, "_oe_after"}, 32'(oe), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    int unsigned base;

    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    do_write(24'h000010, 2, 8'hA5, 8'h3C);
    do_read("rd10", 24'h000010, 2);

    do_write(24'h0000FF, 2, 8'h11, 8'h22);
    do_read("rd00", 24'h000000, 1);
    do_read("rdwrap", 24'h0000FF, 2);

    do_read("rdhi", 24'hABCD10, 2);

    base = err_hits;
    spi_begin();
    oe_any = 1'b0;
    oe_all = 1'b1;
    spi_bits(8'h9F, 8, rx);
    oe_any = 1'b0;
    for (int unsigned i = 0; i < 4; i++) spi_bits(8'hFF, 8, rx);
    check("ign_oe", 32'(oe_any), 32'd0);
    check("ign_miso", 32'(miso), 32'd0);
    check("ign_busy", 32'(busy), 32'd1);
    spi_end();
    check("ign_busy_after", 32'(busy), 32'd0);
    check("ign_err_count", err_hits - base, 32'd1);
    do_read("rdign", 24'h000010, 2);

    do_write(24'h000020, 1, 8'h77, 8'h00);
    spi_begin();
    spi_hdr(SPI_CMD_WRITE, 24'h000020);
    spi_bits(8'hC8, 5, rx);
    spi_end();
    do_read("rdpart", 24'h000020, 1);

    base = err_hits;
    spi_begin();
    spi_bits(8'h9F, 4, rx);
    spi_end();
    check("pcmd_err_count", err_hits - base, 32'd0);
    check("pcmd_busy", 32'(busy), 32'd0);

    spi_begin();
    spi_hdr(SPI_CMD_READ, 24'h000010);
    spi_bits(8'h00, 3, rx);
    check("prerst_bits", 32'(rx[2:0]), 32'(model[8'h10][7:5]));
    check("prerst_oe", 32'(oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_oe", 32'(oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_err", 32'(cmd_err), 32'd0);
    cs_n = 1'b1;
    sck = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    do_read("rdpostrst", 24'h000010, 2);

    check("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
